// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction prefetch buffer between the PC register and decode.
// Issues instruction-bus reads for PC addresses, tracks up to MAX_OUTST reads in
// flight, queues returned instructions with their addresses in a DEPTH-entry
// FIFO and hands them to decode with a valid/ready handshake. A flush empties
// the queue and arranges for every read still in flight to be discarded.
// Optional build macro IF_BUF_BYPASS_EN: a kept response arriving while the
// FIFO is empty and decode is ready goes straight to decode in the same cycle.
module if_fetch_buf #(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              dm_halt_req_i,
    input  logic              flush_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [DATA_W-1:0] ibus_rdata_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              id_ready_i
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;
    // The address queue always has four slots so a 2-bit index never overruns
    // it; only the first MAX_OUTST slots are used.
    localparam int AQ_SLOTS = 4;
    localparam logic [1:0]        MAX_OUTST_L = 2'(MAX_OUTST);
    localparam logic [1:0]        AQ_LAST     = 2'(MAX_OUTST - 1);
    localparam logic [SUM_W-1:0]  DEPTH_L     = SUM_W'(DEPTH);
    localparam logic [DATA_W-1:0] NOP_INST    = DATA_W'(32'h0000_0013);

    // Instruction FIFO storage and control
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // In-flight read bookkeeping
    logic [ADDR_W-1:0] aq_q [AQ_SLOTS];
    logic [1:0]        aq_wr_q, aq_wr_d;
    logic [1:0]        aq_rd_q, aq_rd_d;
    logic [1:0]        outst_q, outst_d;
    logic [1:0]        drop_q, drop_d;

    logic [SUM_W-1:0]  inflight;
    logic              credit_ok;
    logic              grant;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              fifo_empty;
    logic              bypass;
    logic              push;
    logic              pop;

    // Entries already buffered plus reads that will still be kept must fit in
    // the FIFO, so a response can never find it full.
    assign inflight   = SUM_W'(count_q) + SUM_W'(outst_q) - SUM_W'(drop_q);
    assign credit_ok  = (outst_q < MAX_OUTST_L) && (inflight < DEPTH_L);
    assign ibus_req_o = pc_valid_i & ~flush_i & ~dm_halt_req_i & credit_ok;
    assign ibus_addr_o = pc_i;
    assign grant      = ibus_req_o & ibus_gnt_i;
    assign pc_ready_o = grant;

    assign fifo_empty = (count_q == '0);
    assign rsp_drop   = ibus_rvalid_i & (drop_q != 2'd0);
    assign rsp_keep   = ibus_rvalid_i & (drop_q == 2'd0);

`ifdef IF_BUF_BYPASS_EN
    assign bypass = rsp_keep & fifo_empty & id_ready_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A response landing in a flush cycle is discarded with the rest of the queue.
    assign push = rsp_keep & ~flush_i & ~bypass;
    assign pop  = ~fifo_empty & id_ready_i & ~flush_i;

    // Next-state computation for pointers, counters and drop accounting
    always_comb begin
        outst_d  = outst_q;
        drop_d   = drop_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        aq_wr_d  = aq_wr_q;
        aq_rd_d  = aq_rd_q;

        if (grant && !ibus_rvalid_i) begin
            outst_d = outst_q + 2'd1;
        end else if (!grant && ibus_rvalid_i) begin
            outst_d = outst_q - 2'd1;
        end

        if (rsp_drop) begin
            drop_d = drop_q - 2'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (grant) begin
            aq_wr_d = (aq_wr_q == AQ_LAST) ? 2'd0 : aq_wr_q + 2'd1;
        end
        if (rsp_keep) begin
            aq_rd_d = (aq_rd_q == AQ_LAST) ? 2'd0 : aq_rd_q + 2'd1;
        end

        // Every read still in flight after this cycle belongs to the old stream.
        if (flush_i) begin
            drop_d   = outst_d;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            aq_wr_d  = 2'd0;
            aq_rd_d  = 2'd0;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_q  <= 2'd0;
            drop_q   <= 2'd0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            aq_wr_q  <= 2'd0;
            aq_rd_q  <= 2'd0;
        end else begin
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            aq_wr_q  <= aq_wr_d;
            aq_rd_q  <= aq_rd_d;
        end
    end

    // Storage arrays need no reset: validity is carried by the pointers and count
    always_ff @(posedge clk) begin
        if (grant) begin
            aq_q[aq_wr_q] <= pc_i;
        end
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= aq_q[aq_rd_q];
            fifo_data_q[wr_ptr_q] <= ibus_rdata_i;
        end
    end

    // Present the FIFO head (or a bypassed response) to decode; NOP/0 when idle
    always_comb begin
        inst_valid_o = ~fifo_empty;
        inst_o       = fifo_data_q[rd_ptr_q];
        inst_addr_o  = fifo_addr_q[rd_ptr_q];
        if (bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = ibus_rdata_i;
            inst_addr_o  = aq_q[aq_rd_q];
        end
        if (!inst_valid_o) begin
            inst_o      = NOP_INST;
            inst_addr_o = '0;
        end
    end

`ifndef SYNTHESIS
    // A response is only legal while at least one read is in flight.
    rvalid_needs_outst: assert property (@(posedge clk) disable iff (rst)
        ibus_rvalid_i |-> (outst_q != 2'd0));
`endif

endmodule
